// File: rtl/ram_reader_pkg.sv
// ---------------------------------------------------------------------------
// ram_reader_pkg
// Shared definitions for the RAM stream reader: FSM state encoding and the
// output buffer geometry.
// ---------------------------------------------------------------------------
package ram_reader_pkg;

    // Output buffer depth. Two entries is enough to cover one in-flight RAM
    // read plus one word held under backpressure at full throughput.
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// ram_stream_reader_if
// Valid/ready word stream leaving the RAM stream reader.
//   out_valid  word available
//   out_ready  consumer accepts the word this cycle
//   out_data   stream word
//   out_last   final word of the current command
// master: the reader (producer); slave: the consumer.
// ---------------------------------------------------------------------------
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/ram_reader_fifo.sv
// ---------------------------------------------------------------------------
// ram_reader_fifo
// Small synchronous FIFO buffering RAM read data ahead of the stream output.
//   clk, reset  clock, synchronous active-high reset
//   push        write push_data this cycle
//   pop         remove the head word this cycle
//   pop_data    head word (valid when !empty)
//   count       number of stored words
//   empty       no words stored
// Push and pop together on a full FIFO is legal: the slot being written is
// the head that is leaving on the same edge. Pointer wrap relies on
// FIFO_DEPTH being a power of two.
// ---------------------------------------------------------------------------
module ram_reader_fifo
    import ram_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  empty
);

    logic [WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: storage is reset here (tiny array) so the stream data
            // output reads zero after reset; larger memories would not be.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
// Walks a contiguous, wrap-around RAM address range on a start command and
// streams the read words out on a valid/ready interface.
//   clk, reset          clock, synchronous active-high reset
//   start               command strobe (sampled only when idle)
//   base_addr, len      first address and word count (0..2^ADD_WIDTH)
//   busy, done          command in progress / 1-cycle completion pulse
//   mem_we, mem_addr,
//   mem_data, mem_rdata RAM port (read-only use; rdata lags addr by 1 cycle)
//   out                 output stream (master side)
// A read is issued in a cycle where mem_addr is presented and buffer credit
// is available; its data is pushed into the FIFO one cycle later.
// ---------------------------------------------------------------------------
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADD_WIDTH-1:0]   base_addr,
    input  logic [ADD_WIDTH:0]     len,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_we,
    output logic [ADD_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_data,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    ram_stream_reader_if.master    out
);

    localparam int CNT_W    = ADD_WIDTH + 1;
    localparam int CREDIT_W = FIFO_CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                state;
    state_t                state_next;
    logic                  done_next;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  rd_valid;      // mem_rdata carries an issued read
    logic                  issue;
    logic                  pop;
    logic                  accept;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [CREDIT_W-1:0]   credit_used;
    logic [CREDIT_W-1:0]   credit_limit;

    ram_reader_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_valid),
        .push_data (mem_rdata),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign mem_we   = 1'b0;
    assign mem_data = '0;
    assign busy     = (state != ST_IDLE);

    assign out.out_valid = !fifo_empty;
    assign out.out_data  = fifo_data;
    assign out.out_last  = !fifo_empty && (beat_cnt == CNT_ONE);

    assign pop    = !fifo_empty && out.out_ready;
    assign accept = (state == ST_IDLE) && start && (len != '0);

    // Credit: stored + in-flight - popped < depth, rearranged to avoid an
    // unsigned underflow when a pop coincides with an empty pipeline.
    assign credit_used  = CREDIT_W'(fifo_count) + CREDIT_W'(rd_valid);
    assign credit_limit = CREDIT_W'(FIFO_DEPTH) + CREDIT_W'(pop);
    assign issue        = (state == ST_READ) && (credit_used < credit_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_next = state;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) state_next = ST_READ;
                    else           done_next  = 1'b1;
                end
            end
            ST_READ: begin
                if (issue && (issue_cnt == CNT_ONE)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && (beat_cnt == CNT_ONE)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= issue;
            if (accept) begin
                mem_addr  <= base_addr;
                issue_cnt <= len;
                beat_cnt  <= len;
            end else begin
                if (issue) begin
                    mem_addr  <= mem_addr + 1'b1;   // wraps modulo 2^ADD_WIDTH
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (pop) begin
                    beat_cnt <= beat_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
// Directed bench for ram_stream_reader with a behavioural RAM (RAM[i] = i+1).
// Cycle n is the clock period that ends at rising edge n; inputs change and
// outputs are sampled 1 time unit after an edge.
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] ram [16];

    ram_stream_reader_if #(.DATA_WIDTH(DW)) sif();

    ram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADD_WIDTH  (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_rdata (mem_rdata),
        .out       (sif)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_errs = 0;
    beat_t beats_q[$];
    int    done_q[$];

    function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic l, input int c);
        beat_t b;
        b.data = d;
        b.last = l;
        b.cyc  = c;
        return b;
    endfunction

    // Log handshakes and done pulses with the number of the cycle they occur in.
    always @(posedge clk) begin
        if (!reset) begin
            if (sif.out_valid && sif.out_ready)
                beats_q.push_back(mk_beat(sif.out_data, sif.out_last, cyc + 1));
            if (done)
                done_q.push_back(cyc + 1);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l, output int k);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        tick();
        start = 1'b0;
        k     = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_q.size() == 0) check("done_timeout", 32'(done_q.size()), 1);
    endtask

    task automatic check_stream(input string tag, input int b, input int l);
        check($sformatf("%s_count", tag), 32'(beats_q.size()), 32'(l));
        for (int i = 0; i < l && i < beats_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(beats_q[i].data), 32'(((b + i) % 16) + 1));
            check($sformatf("%s_last%0d", tag, i), 32'(beats_q[i].last), 32'(i == l - 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),          0);
        check({tag, "_done"},      32'(done),          0);
        check({tag, "_out_valid"}, 32'(sif.out_valid), 0);
        check({tag, "_out_last"},  32'(sif.out_last),  0);
        check({tag, "_out_data"},  32'(sif.out_data),  0);
        check({tag, "_mem_addr"},  32'(mem_addr),      0);
        check({tag, "_mem_we"},    32'(mem_we),        0);
        check({tag, "_mem_data"},  32'(mem_data),      0);
    endtask

    task automatic clear_logs();
        beats_q.delete();
        done_q.delete();
    endtask

    initial begin
        int k;
        int n;
        int incr;
        int occ;
        int max_occ;
        int stable_errs;
        int seen_valid;
        int seen_busy;
        logic [AW-1:0] prev_addr;
        logic          p_valid;
        logic          p_ready;
        logic          p_last;
        logic [DW-1:0] p_data;

        for (int i = 0; i < 16; i++) ram[i] = 8'(i + 1);
        reset         = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        len           = '0;
        sif.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        tick();

        // 1: base 0, len 10, ready high: beats 1..10 in cycles k+3..k+12, done in k+13
        clear_logs();
        sif.out_ready = 1'b1;
        do_start(4'd0, 5'd10, k);
        check("t1_busy_k1", 32'(busy), 1);
        check("t1_addr_k1", 32'(mem_addr), 0);
        wait_done(40);
        repeat (2) tick();
        check_stream("t1", 0, 10);
        for (int i = 0; i < beats_q.size(); i++)
            check($sformatf("t1_cyc%0d", i), 32'(beats_q[i].cyc - k), 32'(3 + i));
        check("t1_done_count", 32'(done_q.size()), 1);
        if (done_q.size() > 0) check("t1_done_cyc", 32'(done_q[0] - k), 13);
        check("t1_busy_end", 32'(busy), 0);

        // 2: wrap-around, base 14, len 4
        clear_logs();
        do_start(4'd14, 5'd4, k);
        check("t2_addr0", 32'(mem_addr), 14);
        tick();
        check("t2_addr1", 32'(mem_addr), 15);
        tick();
        check("t2_addr2", 32'(mem_addr), 0);
        tick();
        check("t2_addr3", 32'(mem_addr), 1);
        wait_done(40);
        repeat (2) tick();
        check_stream("t2", 14, 4);

        // 3: ready toggling every cycle; issue must stall at 2 outstanding words
        clear_logs();
        do_start(4'd0, 5'd10, k);
        incr        = 0;
        max_occ     = 0;
        stable_errs = 0;
        prev_addr   = mem_addr;
        n           = 0;
        while (done_q.size() == 0 && n < 100) begin
            sif.out_ready = ~sif.out_ready;
            p_valid = sif.out_valid;
            p_ready = sif.out_ready;
            p_data  = sif.out_data;
            p_last  = sif.out_last;
            tick();
            n++;
            if (mem_addr != prev_addr) incr++;
            prev_addr = mem_addr;
            occ = incr - beats_q.size();
            if (occ > max_occ) max_occ = occ;
            if (p_valid && !p_ready &&
                (!sif.out_valid || sif.out_data != p_data || sif.out_last != p_last))
                stable_errs++;
        end
        sif.out_ready = 1'b1;
        if (done_q.size() == 0) check("t3_done_timeout", 32'(done_q.size()), 1);
        repeat (2) tick();
        check_stream("t3", 0, 10);
        check("t3_max_outstanding", 32'(max_occ), 2);
        check("t3_hold_stable", 32'(stable_errs), 0);
        check("t3_issues", 32'(incr), 10);

        // 4a: len 0 -> done next cycle, nothing else
        clear_logs();
        do_start(4'd3, 5'd0, k);
        check("t4_done", 32'(done), 1);
        check("t4_busy", 32'(busy), 0);
        seen_valid = 0;
        seen_busy  = 0;
        repeat (5) begin
            tick();
            if (sif.out_valid) seen_valid++;
            if (busy) seen_busy++;
        end
        check("t4_no_valid", 32'(seen_valid), 0);
        check("t4_no_busy", 32'(seen_busy), 0);
        check("t4_done_count", 32'(done_q.size()), 1);
        check("t4_beats", 32'(beats_q.size()), 0);

        // 4b: start while busy is ignored
        clear_logs();
        do_start(4'd0, 5'd3, k);
        start     = 1'b1;
        base_addr = 4'd8;
        len       = 5'd5;
        tick();
        start = 1'b0;
        wait_done(40);
        repeat (4) tick();
        check_stream("t4b", 0, 3);
        check("t4b_done_count", 32'(done_q.size()), 1);

        // 5: reset after 3 beats of a len 8 command
        clear_logs();
        do_start(4'd0, 5'd8, k);
        n = 0;
        while (beats_q.size() < 3 && n < 40) begin
            tick();
            n++;
        end
        if (beats_q.size() < 3) check("t5_beat_timeout", 32'(beats_q.size()), 3);
        reset = 1'b1;
        tick();
        check_idle_outputs("t5_rst");
        reset = 1'b0;
        repeat (6) tick();
        check("t5_no_done", 32'(done_q.size()), 0);
        check("t5_beats", 32'(beats_q.size()), 3);
        check("t5_idle_valid", 32'(sif.out_valid), 0);
        clear_logs();
        do_start(4'd0, 5'd2, k);
        wait_done(40);
        repeat (2) tick();
        check_stream("t5b", 0, 2);

        // 6: full wrap, base 5, len 16; last word comes from address 4 (data 5)
        clear_logs();
        do_start(4'd5, 5'd16, k);
        wait_done(60);
        repeat (2) tick();
        check_stream("t6", 5, 16);
        check("t6_done_count", 32'(done_q.size()), 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side companion to `single_port_memory`. On a start command it walks a contiguous, wrap-around address range, issues synchronous reads to the RAM, and streams the returned words out on a valid/ready interface. A 2-entry buffer absorbs downstream backpressure without losing read data. It sits between the RAM and any consumer, and owns the RAM port while busy.

## Interface
- `DATA_WIDTH`, 8, word width; matches the RAM.
- `ADD_WIDTH`, 4, RAM address width; depth is 2^ADD_WIDTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADD_WIDTH  first address; sampled with `start`.
- `len`  in  ADD_WIDTH+1  word count, 0..2^ADD_WIDTH; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  1-cycle completion pulse.
- `mem_we`  out  1  RAM write enable; constant 0.
- `mem_addr`  out  ADD_WIDTH  RAM address; registered.
- `mem_data`  out  DATA_WIDTH  RAM write data; constant 0.
- `mem_rdata`  in  DATA_WIDTH  RAM read data; valid one cycle after `mem_addr`.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  consumer ready.
- `out_data`  out  DATA_WIDTH  stream word.
- `out_last`  out  1  high with the final word of a command.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE + `start`, `len`≠0 -> READ. Latch `base_addr` into the address counter. Latch `len` into the issue and beat counters.
- IDLE + `start`, `len`=0 -> stay IDLE. Pulse `done` next cycle; no reads, no beats.
- READ: issue one read per cycle while credit allows. Credit rule: FIFO count + in-flight − pop this cycle < 2. On each issue, increment the address and decrement the issue counter. When the last read is issued -> DRAIN.
- DRAIN: wait until the beat counter reaches 0, i.e. the last beat is handshaken. Then -> IDLE and pulse `done`.
- Each issued read produces exactly one FIFO write, one cycle after the address is presented.
- Address arithmetic is modulo 2^ADD_WIDTH. For example, base 14 with len 4 reads addresses 14, 15, 0, 1.
- Handshake: a beat transfers when `out_valid` && `out_ready`. Once asserted, `out_valid`, `out_data` and `out_last` hold stable until the transfer.
- `out_last` is asserted when the beat counter equals 1.
- `start` while busy is ignored. There is no queuing.
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `mem_addr`=0, `mem_we`=0, `mem_data`=0, FIFO empty, FSM IDLE.
- Reset mid-command: abort immediately. Discard the in-flight read and FIFO contents; no `done` pulse.

## Timing
- `start` sampled at edge k.
- `mem_addr`=base during cycle k+1.
- `mem_rdata` is valid during cycle k+2 and is written into the FIFO at edge k+2.
- `out_valid` is high from cycle k+3. First-beat latency is 3 cycles.
- With `out_ready` held high, throughput is 1 word/cycle; an N-word command finishes its last beat in cycle k+2+N.
- `done` is high in the cycle after the last-beat handshake. `busy` drops in that same cycle.
- Backpressure: with `out_ready` low, at most 2 words are buffered and issue stalls. `mem_addr` holds its last value while stalled.

## Structure
- Package `ram_reader_pkg` holds the FSM state encoding and the FIFO depth constant (2).
- Sub-module `ram_reader_fifo` is a 2-entry synchronous FIFO with push/pop/count. Simultaneous push and pop on a full FIFO is legal.
- The top-level module holds the FSM, counters, credit logic and the RAM port.

## Test plan
- Preload RAM[i]=i+1. Start base=0, len=10, `out_ready`=1 -> beats 1..10 in consecutive cycles starting k+3; `out_last` on 10; `done` in cycle k+13.
- Start base=14, len=4 -> `mem_addr` sequence 14, 15, 0, 1; data 15, 16, 1, 2.
- len=10 with `out_ready` toggling 1/0 every cycle -> all 10 words in order, none lost or duplicated; `mem_addr` stalls whenever the FIFO holds 2 words.
- Start with len=0 -> `done` one cycle later; `out_valid` never asserts; `busy` stays 0. Start while busy -> ignored; beat count unchanged.
- Assert `reset` after 3 beats of a len=8 command -> next cycle all outputs at reset values and no `done` pulse. A following start base=0, len=2 -> beats 1, 2.
- len=16 from base=5 -> full wrap, 16 beats; `out_last` on the word from address 4.
